// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the 32x8 memory block it fronts.
package mem_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    localparam logic CLIENT_GAME = 1'b0;
    localparam logic CLIENT_DISP = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select. When both clients are eligible, the client
// that was not granted last wins.
module rr_arb2 (
    input  logic elig_0,
    input  logic elig_1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic winner
);

    always_comb begin
        gnt_valid = elig_0 | elig_1;
        winner    = elig_1 & (~elig_0 | ~last_gnt);
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter and sequencer for the synchronous memory: an issue stage
// that registers one memory command per cycle and a return stage that steers read data.
module mem_arbiter #(
    parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = mem_arbiter_pkg::DATA_W
) (
    input  logic              i_Clk,
    input  logic              i_Rst,

    input  logic              i_req_0,
    input  logic              i_we_0,
    input  logic [ADDR_W-1:0] i_addr_0,
    input  logic [DATA_W-1:0] i_wdata_0,
    output logic              o_gnt_0,
    output logic              o_rvalid_0,
    output logic [DATA_W-1:0] o_rdata_0,

    input  logic              i_req_1,
    input  logic              i_we_1,
    input  logic [ADDR_W-1:0] i_addr_1,
    input  logic [DATA_W-1:0] i_wdata_1,
    output logic              o_gnt_1,
    output logic              o_rvalid_1,
    output logic [DATA_W-1:0] o_rdata_1,

    output logic              o_mem_write_en,
    output logic              o_mem_read_en,
    output logic [ADDR_W-1:0] o_mem_write_addr,
    output logic [ADDR_W-1:0] o_mem_read_addr,
    output logic [DATA_W-1:0] o_mem_write_data,
    input  logic [DATA_W-1:0] i_mem_read_data
);

    import mem_arbiter_pkg::*;

    logic              r_last_gnt;
    logic              r_rd_pending;
    logic              r_rd_tag;
    logic [DATA_W-1:0] r_rdata_0;
    logic [DATA_W-1:0] r_rdata_1;

    logic              elig_0;
    logic              elig_1;
    logic              gnt_valid;
    logic              winner;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // A client is masked while its grant pulse is high so a held request is not granted twice.
    always_comb begin
        elig_0    = i_req_0 & ~o_gnt_0;
        elig_1    = i_req_1 & ~o_gnt_1;
        win_we    = (winner == CLIENT_DISP) ? i_we_1    : i_we_0;
        win_addr  = (winner == CLIENT_DISP) ? i_addr_1  : i_addr_0;
        win_wdata = (winner == CLIENT_DISP) ? i_wdata_1 : i_wdata_0;
    end

    rr_arb2 u_rr_arb2 (
        .elig_0    (elig_0),
        .elig_1    (elig_1),
        .last_gnt  (r_last_gnt),
        .gnt_valid (gnt_valid),
        .winner    (winner)
    );

    // Issue stage registers the command; return stage remembers which client owns the read in flight.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_last_gnt       <= CLIENT_DISP;
            o_gnt_0          <= 1'b0;
            o_gnt_1          <= 1'b0;
            o_mem_write_en   <= 1'b0;
            o_mem_read_en    <= 1'b0;
            o_mem_write_addr <= '0;
            o_mem_read_addr  <= '0;
            o_mem_write_data <= '0;
            r_rd_pending     <= 1'b0;
            r_rd_tag         <= 1'b0;
            r_rdata_0        <= '0;
            r_rdata_1        <= '0;
        end else begin
            o_gnt_0        <= gnt_valid & (winner == CLIENT_GAME);
            o_gnt_1        <= gnt_valid & (winner == CLIENT_DISP);
            o_mem_write_en <= gnt_valid & win_we;
            o_mem_read_en  <= gnt_valid & ~win_we;
            if (gnt_valid) begin
                r_last_gnt <= winner;
                if (win_we) begin
                    o_mem_write_addr <= win_addr;
                    o_mem_write_data <= win_wdata;
                end else begin
                    o_mem_read_addr <= win_addr;
                end
            end
            r_rd_pending <= o_mem_read_en;
            r_rd_tag     <= o_gnt_1;
            if (o_rvalid_0) begin
                r_rdata_0 <= i_mem_read_data;
            end
            if (o_rvalid_1) begin
                r_rdata_1 <= i_mem_read_data;
            end
        end
    end

    // Read data arrives from memory in the return cycle, so it is forwarded directly then and held afterwards.
    always_comb begin
        o_rvalid_0 = r_rd_pending & (r_rd_tag == CLIENT_GAME);
        o_rvalid_1 = r_rd_pending & (r_rd_tag == CLIENT_DISP);
        o_rdata_0  = o_rvalid_0 ? i_mem_read_data : r_rdata_0;
        o_rdata_1  = o_rvalid_1 ? i_mem_read_data : r_rdata_1;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 32x8 synchronous memory behind it.
module tb_mem_arbiter;

    typedef struct {
        logic       client;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } gnt_exp_t;

    typedef struct {
        logic       client;
        logic [7:0] data;
    } rd_exp_t;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_req_0, i_we_0, i_req_1, i_we_1;
    logic [4:0] i_addr_0, i_addr_1;
    logic [7:0] i_wdata_0, i_wdata_1;
    logic       o_gnt_0, o_rvalid_0, o_gnt_1, o_rvalid_1;
    logic [7:0] o_rdata_0, o_rdata_1;
    logic       o_mem_write_en, o_mem_read_en;
    logic [4:0] o_mem_write_addr, o_mem_read_addr;
    logic [7:0] o_mem_write_data;
    logic [7:0] i_mem_read_data;

    logic [7:0] mem [0:31];
    gnt_exp_t   gnt_q [$];
    rd_exp_t    rd_q [$];
    gnt_exp_t   g_exp;
    rd_exp_t    r_exp;
    int         compared   = 0;
    int         mismatched = 0;

    mem_arbiter dut (
        .i_Clk            (i_Clk),
        .i_Rst            (i_Rst),
        .i_req_0          (i_req_0),
        .i_we_0           (i_we_0),
        .i_addr_0         (i_addr_0),
        .i_wdata_0        (i_wdata_0),
        .o_gnt_0          (o_gnt_0),
        .o_rvalid_0       (o_rvalid_0),
        .o_rdata_0        (o_rdata_0),
        .i_req_1          (i_req_1),
        .i_we_1           (i_we_1),
        .i_addr_1         (i_addr_1),
        .i_wdata_1        (i_wdata_1),
        .o_gnt_1          (o_gnt_1),
        .o_rvalid_1       (o_rvalid_1),
        .o_rdata_1        (o_rdata_1),
        .o_mem_write_en   (o_mem_write_en),
        .o_mem_read_en    (o_mem_read_en),
        .o_mem_write_addr (o_mem_write_addr),
        .o_mem_read_addr  (o_mem_read_addr),
        .o_mem_write_data (o_mem_write_data),
        .i_mem_read_data  (i_mem_read_data)
    );

    always #5 i_Clk = ~i_Clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        i_mem_read_data = 8'h00;
    end

    always @(posedge i_Clk) begin
        if (o_mem_write_en) mem[o_mem_write_addr] <= o_mem_write_data;
        if (o_mem_read_en)  i_mem_read_data <= mem[o_mem_read_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expectGnt(input logic c, input logic we, input logic [4:0] a, input logic [7:0] d);
        gnt_exp_t e;
        e.client = c; e.we = we; e.addr = a; e.data = d;
        gnt_q.push_back(e);
    endtask

    task automatic expectRd(input logic c, input logic [7:0] d);
        rd_exp_t e;
        e.client = c; e.data = d;
        rd_q.push_back(e);
    endtask

    // One call drives the client inputs for exactly one cycle, starting just after a rising edge.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [4:0] a1, input logic [7:0] d1);
        i_req_0 = r0; i_we_0 = w0; i_addr_0 = a0; i_wdata_0 = d0;
        i_req_1 = r1; i_we_1 = w1; i_addr_1 = a1; i_wdata_1 = d1;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 5'd0, 8'h00, 0, 0, 5'd0, 8'h00);
    endtask

    task automatic checkResetState();
        checkOutput("rst_gnt_0", o_gnt_0, 0);
        checkOutput("rst_gnt_1", o_gnt_1, 0);
        checkOutput("rst_rvalid_0", o_rvalid_0, 0);
        checkOutput("rst_rvalid_1", o_rvalid_1, 0);
        checkOutput("rst_rdata_0", o_rdata_0, 0);
        checkOutput("rst_rdata_1", o_rdata_1, 0);
        checkOutput("rst_write_en", o_mem_write_en, 0);
        checkOutput("rst_read_en", o_mem_read_en, 0);
        checkOutput("rst_write_addr", o_mem_write_addr, 0);
        checkOutput("rst_read_addr", o_mem_read_addr, 0);
        checkOutput("rst_write_data", o_mem_write_data, 0);
    endtask

    // Monitor pops an expectation whenever the DUT presents a grant or read data.
    always @(negedge i_Clk) begin
        if (o_mem_write_en || o_mem_read_en)
            checkOutput("mem_en_exclusive", {31'd0, o_mem_write_en & o_mem_read_en}, 0);
        if (o_gnt_0 || o_gnt_1) begin
            if (gnt_q.size() == 0) begin
                checkOutput("unexpected_gnt", {30'd0, o_gnt_1, o_gnt_0}, 0);
            end else begin
                g_exp = gnt_q.pop_front();
                checkOutput("gnt_client", {30'd0, o_gnt_1, o_gnt_0}, g_exp.client ? 32'd2 : 32'd1);
                checkOutput("gnt_write_en", o_mem_write_en, g_exp.we);
                checkOutput("gnt_read_en", o_mem_read_en, !g_exp.we);
                if (g_exp.we) begin
                    checkOutput("gnt_write_addr", o_mem_write_addr, g_exp.addr);
                    checkOutput("gnt_write_data", o_mem_write_data, g_exp.data);
                end else begin
                    checkOutput("gnt_read_addr", o_mem_read_addr, g_exp.addr);
                end
            end
        end
        if (o_rvalid_0 || o_rvalid_1) begin
            if (rd_q.size() == 0) begin
                checkOutput("unexpected_rvalid", {30'd0, o_rvalid_1, o_rvalid_0}, 0);
            end else begin
                r_exp = rd_q.pop_front();
                checkOutput("rvalid_client", {30'd0, o_rvalid_1, o_rvalid_0}, r_exp.client ? 32'd2 : 32'd1);
                checkOutput("rdata", r_exp.client ? o_rdata_1 : o_rdata_0, r_exp.data);
            end
        end
    end

    initial begin
        i_Rst = 1'b1;
        i_req_0 = 0; i_we_0 = 0; i_addr_0 = 0; i_wdata_0 = 0;
        i_req_1 = 0; i_we_1 = 0; i_addr_1 = 0; i_wdata_1 = 0;
        #3;
        $display("[TB] reset state");
        checkResetState();
        @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;

        $display("[TB] first contention: both write, client 0 first");
        expectGnt(0, 1, 5'd3, 8'hA5);
        expectGnt(1, 1, 5'd31, 8'h3C);
        applyStimulus(1, 1, 5'd3, 8'hA5, 1, 1, 5'd31, 8'h3C);
        applyStimulus(0, 0, 5'd0, 8'h00, 1, 1, 5'd31, 8'h3C);
        idle(2);

        $display("[TB] client 0 reads back addr 3 and cross-client addr 31");
        expectGnt(0, 0, 5'd3, 8'h00);
        expectRd(0, 8'hA5);
        applyStimulus(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
        idle(3);
        expectGnt(0, 0, 5'd31, 8'h00);
        expectRd(0, 8'h3C);
        applyStimulus(1, 0, 5'd31, 8'h00, 0, 0, 5'd0, 8'h00);
        idle(3);

        $display("[TB] preload addr 1 and 2, then sustained read contention");
        expectGnt(0, 1, 5'd1, 8'h11);
        applyStimulus(1, 1, 5'd1, 8'h11, 0, 0, 5'd0, 8'h00);
        idle(1);
        expectGnt(1, 1, 5'd2, 8'h22);
        applyStimulus(0, 0, 5'd0, 8'h00, 1, 1, 5'd2, 8'h22);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            expectGnt(0, 0, 5'd1, 8'h00);
            expectGnt(1, 0, 5'd2, 8'h00);
            expectRd(0, 8'h11);
            expectRd(1, 8'h22);
        end
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 5'd1, 8'h00, 1, 0, 5'd2, 8'h00);
        idle(3);

        $display("[TB] single client held request: grant every other cycle");
        expectGnt(0, 0, 5'd3, 8'h00);
        expectGnt(0, 0, 5'd3, 8'h00);
        expectRd(0, 8'hA5);
        expectRd(0, 8'hA5);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
        idle(3);

        $display("[TB] reset between read grant and return");
        expectGnt(0, 0, 5'd3, 8'h00);
        applyStimulus(1, 0, 5'd3, 8'h00, 0, 0, 5'd0, 8'h00);
        i_req_0 = 0;
        @(negedge i_Clk);
        #1;
        i_Rst = 1'b1;
        i_req_0 = 1; i_we_0 = 0; i_addr_0 = 5'd31;
        i_req_1 = 1; i_we_1 = 0; i_addr_1 = 5'd3;
        #1;
        checkResetState();
        @(posedge i_Clk);
        #1;
        checkOutput("held_in_reset_gnt_0", o_gnt_0, 0);
        checkOutput("held_in_reset_gnt_1", o_gnt_1, 0);
        expectGnt(0, 0, 5'd31, 8'h00);
        expectGnt(1, 0, 5'd3, 8'h00);
        expectRd(0, 8'h3C);
        expectRd(1, 8'hA5);
        @(posedge i_Clk);
        #1;
        i_Rst = 1'b0;
        @(posedge i_Clk);
        #1;
        applyStimulus(0, 0, 5'd0, 8'h00, 1, 0, 5'd3, 8'h00);
        idle(4);

        checkOutput("gnt_queue_drained", gnt_q.size(), 0);
        checkOutput("rd_queue_drained", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-client round-robin arbiter and sequencer in front of the 32x8 synchronous memory block.
- Issues at most one access per cycle to the memory's write or read port.
- Routes read data back to the requesting client one cycle after the memory command.
- Clients are game logic (client 0) and display/UART readout (client 1).

Parameters:
- ADDR_W, 5, memory address width (32 entries).
- DATA_W, 8, memory data width.

Ports:
- i_Clk  in  1  system clock; all state on rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_req_0  in  1  client 0 access request; held until o_gnt_0.
- i_we_0  in  1  client 0: 1 = write, 0 = read; stable while i_req_0 is high.
- i_addr_0  in  ADDR_W  client 0 address.
- i_wdata_0  in  DATA_W  client 0 write data.
- o_gnt_0  out  1  one-cycle pulse: client 0 command issued.
- o_rvalid_0  out  1  client 0 read data valid.
- o_rdata_0  out  DATA_W  client 0 read data.
- i_req_1, i_we_1, i_addr_1, i_wdata_1, o_gnt_1, o_rvalid_1, o_rdata_1: same as client 0, for client 1.
- o_mem_write_en  out  1  to memory write enable.
- o_mem_read_en  out  1  to memory read enable.
- o_mem_write_addr  out  ADDR_W  to memory.
- o_mem_read_addr  out  ADDR_W  to memory.
- o_mem_write_data  out  DATA_W  to memory.
- i_mem_read_data  in  DATA_W  from memory; valid one cycle after o_mem_read_en.

Behaviour:
- Reset (async, i_Rst=1):
  - All o_gnt_*, o_rvalid_*, o_mem_*_en = 0.
  - All addresses, write data and rdata = 0.
  - Read tag pipeline cleared.
  - r_last_gnt = 1, so client 0 wins the first contention.
- Eligibility in cycle N: i_req_x=1 and o_gnt_x=0. A client's request is masked in the cycle its grant pulse is high, so a held request is never granted twice.
- Arbitration (combinational in cycle N, registered at end of N):
  - One eligible client: that client wins.
  - Both eligible: the client != r_last_gnt wins; r_last_gnt updates to the winner on every grant.
- Cycle N+1 (registered outputs):
  - o_gnt_winner = 1.
  - Write: o_mem_write_en=1 with addr/data of the winner; o_mem_read_en=0.
  - Read: o_mem_read_en=1 with o_mem_read_addr; o_mem_write_en=0.
  - Read and write are never both high in the same cycle.
  - Unused address and data outputs hold their last value.
- Cycle N+2, read only:
  - o_rvalid_winner = 1 for exactly one cycle.
  - o_rdata_winner = i_mem_read_data, steered by a registered 1-bit tag plus valid bit.
  - Total request-to-data latency is 2 cycles.
- Writes produce no rvalid.
- o_rdata_x holds its last value when o_rvalid_x = 0.
- Throughput:
  - One memory command per cycle aggregate.
  - Single client alone: one grant every 2 cycles (masking).
  - Two clients under contention: strictly alternating grants every cycle.
- Ordering: a write granted in cycle N+1 is visible to a read granted in cycle N+2 or later. Same-cycle write/read collisions cannot occur.
- No request: both memory enables = 0 the next cycle; r_last_gnt unchanged.
- Client drops i_req before grant: the request is ignored (no grant, no access).
- Reset mid-operation:
  - In-flight grants and pending rvalid are discarded; no rvalid after reset release.
  - Memory contents are not affected by the arbiter reset.
- State: r_last_gnt (1b), r_rd_pending (1b), r_rd_tag (1b), plus registered grant and memory outputs. No further FSM states; behaviour is a 2-stage pipeline (issue, return).

Decomposition:
- Shared package:
  - ADDR_W = 5 and DATA_W = 8 (shared with the memory block).
  - Client ID constants CLIENT_GAME = 0, CLIENT_DISP = 1.
- Natural sub-module: rr_arb2.
  - Combinational winner select from two eligible bits and r_last_gnt.
  - Reused by later two-master blocks.
- Issue and return pipeline stays in mem_arbiter.

Test Plan:
- Reset: assert i_Rst mid-simulation with requests active -> all outputs 0 asynchronously (before next edge); no gnt/rvalid until release.
- Write then read:
  - Client 0 writes addr 3, data 0xA5 at cycle N -> o_gnt_0 and o_mem_write_en at N+1.
  - Client 0 reads addr 3 at N+2 -> o_rvalid_0=1, o_rdata_0=0xA5 at N+4.
- First contention after reset: both request at N -> o_gnt_0 at N+1, o_gnt_1 at N+2.
- Sustained contention: both hold reads of addrs 1 and 2 for 6 cycles -> grants alternate 0,1,0,1,...; each rvalid carries the correct data for its client 2 cycles after its request was granted-registered.
- Cross-client visibility: client 1 writes addr 31 = 0x3C, then client 0 reads addr 31 -> o_rdata_0 = 0x3C, and o_rvalid_1 never asserts.
- Reset between read grant and return: read granted at N+1, i_Rst pulsed during N+1 -> no o_rvalid at N+2; next request after release serviced normally, client 0 first.
